// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision floating-point datapath blocks.
package fp_pkg;

   localparam int SIGN_W      = 1;
   localparam int EXP_W       = 8;
   localparam int FRAC_W      = 23;
   localparam int MANT_W      = FRAC_W + 1;
   localparam int PROD_W      = 2 * MANT_W;
   localparam int BIAS        = 127;
   localparam int MULT_CYCLES = 24;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_word_t;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MULT,
      NORM,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and packing of a normalised 48-bit significand product
// (leading one at bit 47) into an IEEE-754 single-precision word.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic                sign,
   input  logic signed [9:0]   exp_in,
   input  logic [PROD_W-1:0]   prod,
   output logic [31:0]         word
);

   logic [FRAC_W-1:0] mant;
   logic              guard;
   logic              rnd;
   logic              sticky;
   logic              round_up;
   logic [MANT_W-1:0] sum;
   logic signed [9:0] exp_f;

   // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
   always_comb begin
      mant     = prod[PROD_W-2 -: FRAC_W];
      guard    = prod[PROD_W-2-FRAC_W];
      rnd      = prod[PROD_W-3-FRAC_W];
      sticky   = |prod[PROD_W-4-FRAC_W:0];
      round_up = guard & (rnd | sticky | mant[0]);
      sum      = {1'b0, mant} + {{FRAC_W{1'b0}}, round_up};
      // A carry out of the fraction leaves an all-zero fraction one binade higher.
      exp_f    = exp_in + $signed({9'd0, sum[MANT_W-1]});

      if (exp_f >= 10'sd255)
         word = {sign, POS_INF[30:0]};
      else if (exp_f <= 10'sd0)
         word = {sign, 31'd0};
      else
         word = {sign, exp_f[EXP_W-1:0], sum[FRAC_W-1:0]};
   end

endmodule

// File: rtl/fp_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier: radix-2 shift-add significand
// multiply with fixed 27-cycle latency from start acceptance to the done pulse.
module fp_multiplier
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        clear_b,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] P
);

   state_t            state;
   state_t            state_next;
   fp_word_t          a_reg;
   fp_word_t          b_reg;
   logic [4:0]        cnt;
   logic [PROD_W-1:0] mcand;
   logic [MANT_W-1:0] mplier;
   logic [PROD_W-1:0] prod;
   logic signed [9:0] exp_r;
   logic              sign_r;
   logic              special_r;
   logic [31:0]       special_word_r;
   logic [31:0]       p_r;
   logic [31:0]       rounded;

   logic              sign_ab;
   logic              a_nan, a_inf, a_zero;
   logic              b_nan, b_inf, b_zero;
   logic              special;
   logic [31:0]       special_word;
   logic signed [9:0] exp_sum;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = UNPACK;
         UNPACK:  state_next = MULT;
         MULT:    if (cnt == 5'(MULT_CYCLES - 1)) state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Operand classification; subnormals collapse to zero.
   always_comb begin
      sign_ab = a_reg.sign[0] ^ b_reg.sign[0];
      a_nan   = (a_reg.exp == '1) && (a_reg.frac != '0);
      a_inf   = (a_reg.exp == '1) && (a_reg.frac == '0);
      a_zero  = (a_reg.exp == '0);
      b_nan   = (b_reg.exp == '1) && (b_reg.frac != '0);
      b_inf   = (b_reg.exp == '1) && (b_reg.frac == '0);
      b_zero  = (b_reg.exp == '0);
      exp_sum = $signed({2'b00, a_reg.exp}) + $signed({2'b00, b_reg.exp}) - 10'(BIAS);

      special      = 1'b1;
      special_word = QNAN;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
         special_word = QNAN;
      else if (a_inf || b_inf)
         special_word = {sign_ab, POS_INF[30:0]};
      else if (a_zero || b_zero)
         special_word = {sign_ab, 31'd0};
      else begin
         special      = 1'b0;
         special_word = '0;
      end
   end

   fp_round_pack u_round_pack (
      .sign   (sign_r),
      .exp_in (exp_r),
      .prod   (prod),
      .word   (rounded)
   );

   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         a_reg          <= '0;
         b_reg          <= '0;
         cnt            <= '0;
         mcand          <= '0;
         mplier         <= '0;
         prod           <= '0;
         exp_r          <= '0;
         sign_r         <= 1'b0;
         special_r      <= 1'b0;
         special_word_r <= '0;
         p_r            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= A;
                  b_reg <= B;
               end
            end
            UNPACK: begin
               sign_r         <= sign_ab;
               special_r      <= special;
               special_word_r <= special_word;
               exp_r          <= exp_sum;
               mcand          <= {{MANT_W{1'b0}}, 1'b1, a_reg.frac};
               mplier         <= {1'b1, b_reg.frac};
               prod           <= '0;
               cnt            <= '0;
            end
            MULT: begin
               if (mplier[0])
                  prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
            NORM: begin
               // Keep the leading one at bit 47; a product in [2,4) bumps the exponent instead.
               if (prod[PROD_W-1])
                  exp_r <= exp_r + 10'sd1;
               else
                  prod <= prod << 1;
            end
            ROUND: begin
               p_r <= special_r ? special_word_r : rounded;
            end
            default: ;
         endcase
      end
   end

   assign P = p_r;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed bench for fp_multiplier: latency, rounding, specials, start filtering and abort.
module tb_fp_multiplier;

   logic        clk;
   logic        clear_b;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] P;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   fp_multiplier dut (
      .clk     (clk),
      .clear_b (clear_b),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .P       (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One full operation: checks busy, 27-edge latency, result, and the return to idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected,
                         input string tag, input bit start_in_done);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1'b1;
            n   = i;
         end
      end
      check({tag, "_latency"}, 32'(n), 32'd27);
      check({tag, "_P"}, P, expected);
      if (start_in_done) begin
         start = 1'b1;
         A     = a;
         B     = b;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      check({tag, "_P_held"}, P, expected);
   endtask

   initial begin
      bit done_seen;
      clear_b = 1'b0;
      start   = 1'b0;
      A       = '0;
      B       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_P", P, 32'h0000_0000);
      @(negedge clk);
      clear_b = 1'b1;

      // 0x41280000 encodes 10.5, so 10.5*2.25 = 23.625; 0x41240000 is 10.25.
      run_op(32'h4128_0000, 32'h4010_0000, 32'h41BD_0000, "mul_10p5_2p25", 1'b0);
      run_op(32'h4124_0000, 32'h4010_0000, 32'h41B8_8000, "mul_10p25_2p25", 1'b1);
      run_op(32'h41A4_0000, 32'hC010_0000, 32'hC238_8000, "mul_neg", 1'b0);
      run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "mul_ulp_sq", 1'b0);
      run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, "tie_up_even", 1'b0);
      run_op(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, "tie_down_even", 1'b0);
      run_op(32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, "round_carry", 1'b0);
      run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, "norm_shift", 1'b0);
      run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_times_zero", 1'b0);
      run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "overflow", 1'b0);
      run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in", 1'b0);
      run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "neg_inf", 1'b0);
      run_op(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, "neg_zero", 1'b0);
      run_op(32'h0000_0001, 32'hC000_0000, 32'h8000_0000, "subnormal_in", 1'b0);
      run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow", 1'b0);

      // Abort: second start in MULT is ignored, then reset lands mid-MULT.
      done_seen = 1'b0;
      @(negedge clk);
      A     = 32'h4000_0000;
      B     = 32'h4040_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         done_seen = done_seen | done;
      end
      @(negedge clk);
      start = 1'b1;
      A     = 32'h3F80_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         done_seen = done_seen | done;
      end
      check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
      @(negedge clk);
      clear_b = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_P", P, 32'h0000_0000);
      repeat (2) begin
         @(posedge clk);
         #1;
         done_seen = done_seen | done;
      end
      @(negedge clk);
      clear_b = 1'b1;
      repeat (30) begin
         @(posedge clk);
         #1;
         done_seen = done_seen | done;
      end
      check("abort_no_done", {31'd0, done_seen}, 32'd0);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);
      run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "after_abort", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
